card_dealer: RTL and testbench

Card dealer that builds a shuffled 6x6 deck of 18 pairs and writes it into the 64-entry card memory over the memory's write port. It runs once per game, before card comparison starts, and drives the write side of the card memory that the comparison logic reads. Shuffling is a hardware Fisher-Yates pass on an internal 36-entry deck register array. A 16-bit LFSR supplies the random index.

---
 rtl/card_dealer.sv | 177 +++++++++++++++++
 tb/tb_card_dealer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer
//   Builds a deck of CARDS slots holding PAIRS card values (each value twice),
//   optionally shuffles it with a hardware Fisher-Yates pass, then writes the
//   deck into the DEPTH-word card memory. Addresses CARDS..DEPTH-1 get BLANK.
//
// Configuration macro:
//   CARD_DEALER_SHUFFLE_EN  defined   -> FILL, SHUF (LFSR-driven swaps), WRITE
//                           undefined -> FILL, WRITE (sorted deck, debug)
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   one-cycle deal request, sampled only in IDLE
//   seed     in   16-bit LFSR seed, captured when start is accepted
//   busy     out  high from the cycle after start is accepted until done
//   done     out  one-cycle pulse after the last memory write
//   wEn      out  memory write enable
//   wAddr    out  memory write address
//   wData    out  memory write data

module card_dealer #(
    parameter int unsigned PAIRS = 18,
    parameter int unsigned CARDS = 36,
    parameter int unsigned DEPTH = 64,
    parameter logic [4:0]  BLANK = 5'h1F
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic        wEn,
    output logic [5:0]  wAddr,
    output logic [4:0]  wData
);

    localparam logic [5:0]  NCARDS    = 6'(CARDS);
    localparam logic [5:0]  LAST_CARD = 6'(CARDS - 1);
    localparam logic [5:0]  LAST_ADDR = 6'(DEPTH - 1);
    localparam logic [15:0] SEED_DFLT = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHUF,
        WRITE,
        DONE
    } state_t;

    state_t      state_q;
    logic [5:0]  idx_q;      // i during FILL/SHUF, k during WRITE
    logic        busy_q;
    logic        done_q;
    logic        wen_q;
    logic [5:0]  waddr_q;
    logic [4:0]  wdata_q;
    logic [4:0]  deck_q [CARDS];

`ifdef CARD_DEALER_SHUFFLE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [5:0]  mask_d;
    logic [5:0]  c_d;
    logic [5:0]  j_d;

    // Smearing i rightwards yields 2^ceil(log2(i+1))-1 for i >= 1.
    always_comb begin
        mask_d = idx_q | (idx_q >> 1) | (idx_q >> 2) | (idx_q >> 3)
               | (idx_q >> 4) | (idx_q >> 5);
        c_d    = lfsr_q[5:0] & mask_d;
        j_d    = (c_d > idx_q) ? (c_d - (idx_q + 6'd1)) : c_d;
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
`else
    logic unused_seed;
    assign unused_seed = ^seed;
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef CARD_DEALER_SHUFFLE_EN
            lfsr_q  <= SEED_DFLT;
`endif
        end else begin
            done_q <= 1'b0;
            wen_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q <= FILL;
                        idx_q   <= '0;
`ifdef CARD_DEALER_SHUFFLE_EN
                        lfsr_q  <= (seed == 16'h0000) ? SEED_DFLT : seed;
`endif
                    end
                end
                FILL: begin
                    busy_q <= 1'b1;
                    if (idx_q == LAST_CARD) begin
`ifdef CARD_DEALER_SHUFFLE_EN
                        state_q <= SHUF;
                        idx_q   <= LAST_CARD;
`else
                        state_q <= WRITE;
                        idx_q   <= '0;
`endif
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
`ifdef CARD_DEALER_SHUFFLE_EN
                SHUF: begin
                    busy_q <= 1'b1;
                    lfsr_q <= lfsr_d;
                    if (idx_q == 6'd1) begin
                        state_q <= WRITE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q - 6'd1;
                    end
                end
`endif
                WRITE: begin
                    busy_q  <= 1'b1;
                    wen_q   <= 1'b1;
                    waddr_q <= idx_q;
                    wdata_q <= (idx_q < NCARDS) ? deck_q[idx_q] : BLANK;
                    if (idx_q == LAST_ADDR) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Deck storage has no reset: its contents are rebuilt by FILL every deal.
    always_ff @(posedge clock) begin
        if (state_q == FILL) begin
            deck_q[idx_q] <= idx_q[5:1];
        end
`ifdef CARD_DEALER_SHUFFLE_EN
        else if (state_q == SHUF) begin
            // When j == i both assignments carry the same value.
            deck_q[idx_q] <= deck_q[j_d];
            deck_q[j_d]   <= deck_q[idx_q];
        end
`endif
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign wEn   = wen_q;
    assign wAddr = waddr_q;
    assign wData = wdata_q;

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

`ifdef CARD_DEALER_SHUFFLE_EN
    localparam bit SHUF_EN  = 1'b1;
    localparam int WS       = 72;
    localparam int DONE_CYC = 136;
`else
    localparam bit SHUF_EN  = 1'b0;
    localparam int WS       = 37;
    localparam int DONE_CYC = 101;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        busy, done, wEn;
    logic [5:0]  wAddr;
    logic [4:0]  wData;

    int n_cmp = 0;
    int n_mis = 0;

    logic [4:0] exp_img [64];
    logic [4:0] got_img [64];
    logic [4:0] img_a   [64];
    logic [4:0] img_b   [64];

    // Per-deal observations
    int nwr, ndone, done_cyc, first_wr, pos_err, busy_err;
    logic rst_wen, rst_busy;

    card_dealer #(.PAIRS(18), .CARDS(36), .DEPTH(64), .BLANK(5'h1F)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .seed   (seed),
        .busy   (busy),
        .done   (done),
        .wEn    (wEn),
        .wAddr  (wAddr),
        .wData  (wData)
    );

    always #5 clock = ~clock;

    // Reference deal: sorted pairs, then Fisher-Yates from i=35 down to 1.
    function automatic void build_ref(input logic [15:0] sd);
        int deck [36];
        int unsigned l, m, c, j, t;
        for (int k = 0; k < 36; k++) deck[k] = k / 2;
        if (SHUF_EN) begin
            l = (sd == 16'h0000) ? 32'hACE1 : 32'(sd);
            for (int i = 35; i >= 1; i--) begin
                m = 1;
                while (m < 32'(i + 1)) m = m * 2;
                c = (l % 64) & (m - 1);
                j = (c > 32'(i)) ? c - 32'(i) - 1 : c;
                t = deck[i]; deck[i] = deck[j]; deck[j] = t;
                l = (l >> 1) ^ (((l & 1) != 0) ? 32'hB400 : 32'h0);
            end
        end
        for (int k = 0; k < 64; k++)
            exp_img[k] = (k < 36) ? 5'(deck[k]) : 5'h1F;
    endfunction

    // Drives one deal and records what the DUT did, cycle by cycle.
    // r0..r2: cycles at which start is re-asserted; rst_at: cycle to pull reset.
    task automatic do_deal(input logic [15:0] sd, input int r0, input int r1,
                           input int r2, input int rst_at);
        bit exp_busy;
        for (int k = 0; k < 64; k++) got_img[k] = 'x;
        nwr = 0; ndone = 0; done_cyc = -1; first_wr = -1;
        pos_err = 0; busy_err = 0; rst_wen = 1'bx; rst_busy = 1'bx;
        @(negedge clock);
        seed  = sd;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int n = 1; n <= DONE_CYC + 20; n++) begin
            @(posedge clock);
            #1;
            if (wEn === 1'b1) begin
                if (first_wr < 0) first_wr = n;
                if (wAddr !== 6'(nwr) || n != WS + nwr) pos_err++;
                got_img[wAddr] = wData;
                nwr++;
            end else if (wEn !== 1'b0) begin
                pos_err++;
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = n;
            end
            exp_busy = (n <= DONE_CYC) && (rst_at < 0 || n <= rst_at);
            if (busy !== exp_busy) busy_err++;
            if (n == rst_at) begin
                reset_n = 1'b0;
                #1;
                rst_wen  = wEn;
                rst_busy = busy;
            end
            if (rst_at >= 0 && n == rst_at + 3) reset_n = 1'b1;
            start = (n + 1 == r0) || (n + 1 == r1) || (n + 1 == r2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int wcount, bcount;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (wEn !== 1'b0) begin n_mis++; $display("FAIL reset_wEn got=%b exp=0", wEn); end
        n_cmp++; if (wAddr !== 6'd0) begin n_mis++; $display("FAIL reset_wAddr got=%h exp=0", wAddr); end
        n_cmp++; if (wData !== 5'd0) begin n_mis++; $display("FAIL reset_wData got=%h exp=0", wData); end
        @(negedge clock);
        reset_n = 1'b1;
        start   = 1'b0;
        wcount = 0; bcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            if (wEn !== 1'b0) wcount++;
            if (busy !== 1'b0) bcount++;
        end
        n_cmp++; if (wcount != 0) begin n_mis++; $display("FAIL idle_writes got=%0d exp=0", wcount); end
        n_cmp++; if (bcount != 0) begin n_mis++; $display("FAIL idle_busy got=%0d exp=0", bcount); end
    endtask

    // Checks a completed, undisturbed deal against the reference for sd.
    task automatic test_deal(input logic [15:0] sd, input string tag);
        int cnt [18];
        int blanks, bad;
        do_deal(sd, -1, -1, -1, -1);
        build_ref(sd);
        n_cmp++; if (first_wr != WS) begin n_mis++; $display("FAIL %s first_write got=%0d exp=%0d", tag, first_wr, WS); end
        n_cmp++; if (nwr != 64) begin n_mis++; $display("FAIL %s writes got=%0d exp=64", tag, nwr); end
        n_cmp++; if (pos_err != 0) begin n_mis++; $display("FAIL %s write_order got=%0d exp=0", tag, pos_err); end
        n_cmp++; if (ndone != 1 || done_cyc != DONE_CYC) begin n_mis++; $display("FAIL %s done got=%0d@%0d exp=1@%0d", tag, ndone, done_cyc, DONE_CYC); end
        n_cmp++; if (busy_err != 0) begin n_mis++; $display("FAIL %s busy_window got=%0d exp=0", tag, busy_err); end
        for (int v = 0; v < 18; v++) cnt[v] = 0;
        blanks = 0; bad = 0;
        for (int k = 0; k < 36; k++) begin
            if (!$isunknown(got_img[k]) && got_img[k] < 5'd18) cnt[got_img[k]]++;
            else bad++;
        end
        for (int k = 36; k < 64; k++) if (got_img[k] === 5'h1F) blanks++;
        for (int v = 0; v < 18; v++) begin
            n_cmp++; if (cnt[v] != 2) begin n_mis++; $display("FAIL %s pair_count v=%0d got=%0d exp=2", tag, v, cnt[v]); end
        end
        n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL %s bad_values got=%0d exp=0", tag, bad); end
        n_cmp++; if (blanks != 28) begin n_mis++; $display("FAIL %s blanks got=%0d exp=28", tag, blanks); end
        for (int k = 0; k < 64; k++) begin
            n_cmp++; if (got_img[k] !== exp_img[k]) begin n_mis++; $display("FAIL %s image addr=%0d got=%h exp=%h", tag, k, got_img[k], exp_img[k]); end
        end
        n_cmp++; if (wAddr !== 6'd63 || wData !== 5'h1F) begin n_mis++; $display("FAIL %s hold got=%h/%h exp=3f/1f", tag, wAddr, wData); end
    endtask

    task automatic test_seed_sensitivity();
        int diffs;
        test_deal(16'h1234, "seed1234_a");
        img_a = got_img;
        test_deal(16'h1234, "seed1234_b");
        diffs = 0;
        for (int k = 0; k < 64; k++) if (got_img[k] !== img_a[k]) diffs++;
        n_cmp++; if (diffs != 0) begin n_mis++; $display("FAIL repeat_seed diffs got=%0d exp=0", diffs); end
        test_deal(16'h0000, "seed0000");
        img_b = got_img;
        test_deal(16'hACE1, "seedACE1");
        diffs = 0;
        for (int k = 0; k < 64; k++) if (got_img[k] !== img_b[k]) diffs++;
        n_cmp++; if (diffs != 0) begin n_mis++; $display("FAIL zero_seed diffs got=%0d exp=0", diffs); end
        test_deal(16'h0001, "seed0001");
`ifdef CARD_DEALER_SHUFFLE_EN
        diffs = 0;
        for (int k = 0; k < 64; k++) if (got_img[k] !== img_a[k]) diffs++;
        n_cmp++; if (diffs == 0) begin n_mis++; $display("FAIL seed_differs diffs got=0 exp=nonzero"); end
`endif
    endtask

    task automatic test_random_seeds();
        logic [15:0] sd;
        for (int t = 0; t < 3; t++) begin
            sd = 16'($urandom_range(0, 65535));
            test_deal(sd, "random");
        end
    endtask

    task automatic test_start_ignored();
        int bad;
        do_deal(16'h5A5A, 5, 50, 100, -1);
        build_ref(16'h5A5A);
        n_cmp++; if (nwr != 64) begin n_mis++; $display("FAIL restart_writes got=%0d exp=64", nwr); end
        n_cmp++; if (ndone != 1 || done_cyc != DONE_CYC) begin n_mis++; $display("FAIL restart_done got=%0d@%0d exp=1@%0d", ndone, done_cyc, DONE_CYC); end
        n_cmp++; if (pos_err != 0 || busy_err != 0) begin n_mis++; $display("FAIL restart_timing got=%0d/%0d exp=0/0", pos_err, busy_err); end
        bad = 0;
        for (int k = 0; k < 64; k++) if (got_img[k] !== exp_img[k]) bad++;
        n_cmp++; if (bad != 0) begin n_mis++; $display("FAIL restart_image diffs got=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_deal();
        do_deal(16'h2468, -1, -1, -1, 90);
        n_cmp++; if (rst_wen !== 1'b0) begin n_mis++; $display("FAIL midreset_wEn got=%b exp=0", rst_wen); end
        n_cmp++; if (rst_busy !== 1'b0) begin n_mis++; $display("FAIL midreset_busy got=%b exp=0", rst_busy); end
        n_cmp++; if (ndone != 0) begin n_mis++; $display("FAIL midreset_done got=%0d exp=0", ndone); end
        n_cmp++; if (nwr != 90 - WS + 1 || pos_err != 0) begin n_mis++; $display("FAIL midreset_writes got=%0d err=%0d exp=%0d", nwr, pos_err, 90 - WS + 1); end
        n_cmp++; if (busy_err != 0) begin n_mis++; $display("FAIL midreset_busy_window got=%0d exp=0", busy_err); end
        test_deal(16'(32'h2468 + $urandom_range(1, 255)), "after_reset");
    endtask

    initial begin
        test_reset();
        test_seed_sensitivity();
        test_random_seeds();
        test_start_ignored();
        test_reset_mid_deal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
